// File: rtl/tcnt_pkg.sv
// Shared constants and elaboration helpers for the T-cell modulo counter.
package tcnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal value of the count range, truncated to the counter width.
  function automatic int max_for_mod(input int modulus, input int width);
    return (modulus - 1) & ((1 << width) - 1);
  endfunction

  function automatic bit mod_is_legal(input int modulus, input int width);
    return (width >= 1) && (width <= 16) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/t_mod_counter_t_ff_cell.sv
// Single T flip-flop: toggles on a rising edge when t is high, cleared asynchronously.
module t_ff_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic t,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_mod_counter.sv
// Modulo up/down counter built from a bank of T cells; toggles come from q ^ q_next.
module t_mod_counter
  import tcnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_for_mod(MODULUS, WIDTH));
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  if (!mod_is_legal(MODULUS, WIDTH)) begin : g_bad_params
    $error("t_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH with WIDTH in 1..16");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] t_vec_q;
  logic             wrap_q;
  logic             wrap_d;
  logic             ld_err_q;
  logic             ld_err_d;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;

  assign at_max       = (q_q == MAX_Q);
  assign at_zero      = (q_q == '0);
  assign out_of_range = (q_q > MAX_Q);

  // Out-of-range values recover to the nearest legal end without signalling a wrap.
  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (ld) begin
      if (ld_val > MAX_Q) begin
        q_d      = MAX_Q;
        ld_err_d = 1'b1;
      end else begin
        q_d = ld_val;
      end
    end else if (en) begin
      if (up == DIR_UP) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else if (out_of_range) begin
          q_d = '0;
        end else begin
          q_d = q_q + ONE_Q;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_Q;
          wrap_d = 1'b1;
        end else if (out_of_range) begin
          q_d = MAX_Q;
        end else begin
          q_d = q_q - ONE_Q;
        end
      end
    end
  end

  assign t_d = q_q ^ q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk   (clk),
      .clr_n (clr_n),
      .t     (t_d[i]),
      .q     (q_q[i])
    );
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_vec_q  <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      t_vec_q  <= t_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign q      = q_q;
  assign t_vec  = t_vec_q;
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;
  assign tc     = en & ~ld & ((up == DIR_UP) ? at_max : at_zero);

endmodule

// File: tb/tb_t_mod_counter.sv
// Scoreboard bench for t_mod_counter: modulo-10 main instance, a two-digit cascade and a modulo-16 instance.
module tb_t_mod_counter;

  localparam int MOD = 10;

  typedef struct {
    int q;
    int t;
    int wrap;
    int lderr;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       en = 1'b0, up = 1'b1, ld = 1'b0;
  logic [3:0] ld_val = '0;
  logic [3:0] q, t_vec;
  logic       tc, wrap, ld_err;

  logic       en_c = 1'b0;
  logic [3:0] q_lo, q_hi, tv_lo, tv_hi;
  logic       tc_lo, tc_hi, wr_lo, wr_hi, le_lo, le_hi;

  logic       en16 = 1'b0, ld16 = 1'b0;
  logic [3:0] ldv16 = '0;
  logic [3:0] q16, tv16;
  logic       tc16, wr16, le16;

  int   checks = 0;
  int   failures = 0;
  int   mq = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  t_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .q(q), .t_vec(t_vec), .tc(tc), .wrap(wrap), .ld_err(ld_err)
  );

  t_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clr_n(clr_n), .en(en_c), .up(1'b1), .ld(1'b0), .ld_val(4'd0),
    .q(q_lo), .t_vec(tv_lo), .tc(tc_lo), .wrap(wr_lo), .ld_err(le_lo)
  );

  t_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .clr_n(clr_n), .en(tc_lo), .up(1'b1), .ld(1'b0), .ld_val(4'd0),
    .q(q_hi), .t_vec(tv_hi), .tc(tc_hi), .wrap(wr_hi), .ld_err(le_hi)
  );

  t_mod_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .clr_n(clr_n), .en(en16), .up(1'b1), .ld(ld16), .ld_val(ldv16),
    .q(q16), .t_vec(tv16), .tc(tc16), .wrap(wr16), .ld_err(le16)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic on an integer count.
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] v);
    exp_t x;
    int   nq;
    @(negedge clk);
    en = e; up = u; ld = l; ld_val = v;
    #1;
    chk("tc", int'(tc), int'(e && !l && (u ? (mq == MOD - 1) : (mq == 0))));
    x.wrap = 0;
    x.lderr = 0;
    if (l) begin
      if (int'(v) < MOD) nq = int'(v);
      else begin
        nq = MOD - 1;
        x.lderr = 1;
      end
    end else if (e) begin
      if (u) begin
        nq = (mq + 1) % MOD;
        x.wrap = int'(mq == MOD - 1);
      end else begin
        nq = (mq + MOD - 1) % MOD;
        x.wrap = int'(mq == 0);
      end
    end else begin
      nq = mq;
    end
    x.q = nq;
    x.t = mq ^ nq;
    mq = nq;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("q", int'(q), x.q);
      chk("t_vec", int'(t_vec), x.t);
      chk("wrap", int'(wrap), x.wrap);
      chk("ld_err", int'(ld_err), x.lderr);
    end
  end

  initial begin
    int mlo;
    int mhi;
    int m16;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_t_vec", int'(t_vec), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_ld_err", int'(ld_err), 0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    #2;
    chk("up_end_q", int'(q), 2);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    chk("dn_end_q", int'(q), 8);

    step(1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b0, 1'b1, 4'd12);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b1, 4'd15);

    // Async clear between edges
    step(1'b0, 1'b1, 1'b1, 4'd5);
    @(negedge clk);
    en = 1'b0; ld = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("aclr_q", int'(q), 0);
    chk("aclr_t_vec", int'(t_vec), 0);
    chk("aclr_wrap", int'(wrap), 0);
    mq = 0;
    @(negedge clk);
    clr_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 4'd0);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    en = 1'b0; ld = 1'b0;
    chk("sb_drained", sb.size(), 0);

    // Two-digit cascade, both digits start from 0
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    mlo = 0;
    mhi = 0;
    en_c = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (mlo == 9) mhi = (mhi + 1) % 10;
      mlo = (mlo + 1) % 10;
      chk("casc_lo", int'(q_lo), mlo);
      chk("casc_hi", int'(q_hi), mhi);
    end
    @(negedge clk);
    en_c = 1'b0;
    chk("casc_final", int'({q_hi, q_lo}), int'({4'd2, 4'd5}));

    // Power-of-two modulus
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    m16 = 0;
    en16 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      chk("m16_wrap", int'(wr16), int'(m16 == 15));
      m16 = (m16 + 1) % 16;
      chk("m16_q", int'(q16), m16);
    end
    @(negedge clk);
    en16 = 1'b0;
    ld16 = 1'b1;
    ldv16 = 4'd15;
    @(posedge clk);
    #1;
    chk("m16_ld_q", int'(q16), 15);
    chk("m16_ld_err", int'(le16), 0);
    @(negedge clk);
    ld16 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
